bin_to_bcd: RTL

Sequential binary-to-BCD converter (iterative double-dabble, one bit per clock) that produces the packed decimal digit vector consumed by the on-screen number renderer `vga_number`. Game logic hands it a binary score/counter value with a start pulse. After a fixed latency it presents a stable, registered BCD word, one 4-bit nibble per displayed digit. The output holds until the next conversion completes, so the renderer never sees a partially converted value mid-frame.

---
 rtl/bin_to_bcd_if.sv | 24 ++
 rtl/bin_to_bcd.sv | 102 ++++++++++
 2 files changed

// File: rtl/bin_to_bcd_if.sv
// Handshake and result bus between game logic and the binary-to-BCD converter.
interface bin_to_bcd_if #(
  parameter int BIN_WIDTH   = 27,
  parameter int DIGIT_COUNT = 8
);
  logic [BIN_WIDTH-1:0]     bin;
  logic                     start;
  logic                     ready;
  logic                     done;
  logic [DIGIT_COUNT*4-1:0] bcd;
  logic                     overflow;

  // Requester side: supplies the value and the start pulse.
  modport master (
    output bin, start,
    input  ready, done, bcd, overflow
  );

  // Converter side.
  modport slave (
    input  bin, start,
    output ready, done, bcd, overflow
  );
endinterface

// File: rtl/bin_to_bcd.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// The result word is registered and only changes when a conversion
// finishes, so downstream renderers never see a partial value.
module bin_to_bcd #(
  parameter int BIN_WIDTH   = 27,
  parameter int DIGIT_COUNT = 8
) (
  input logic        clock,
  input logic        reset,
  bin_to_bcd_if.slave bus
);
  localparam int BCD_W = DIGIT_COUNT * 4;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Smallest value that no longer fits in DIGIT_COUNT decimal digits.
  localparam longint unsigned OVF_LIMIT = pow10(DIGIT_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [BIN_WIDTH-1:0] shreg;
  logic [BCD_W-1:0]     scratch;
  logic [BCD_W-1:0]     scratch_adj;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_flag;
  logic                 accept;

  assign bus.ready = (state == IDLE);
  assign accept    = bus.start && (state == IDLE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction for every scratch digit that would reach 10+ on the shift.
  always_comb begin
    scratch_adj = scratch;
    for (int unsigned d = 0; d < DIGIT_COUNT; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  // Conversion datapath and registered result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg        <= '0;
      scratch      <= '0;
      cnt          <= '0;
      ovf_flag     <= 1'b0;
      bus.bcd      <= '0;
      bus.overflow <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg    <= bus.bin;
            scratch  <= '0;
            cnt      <= CNT_W'(BIN_WIDTH);
            ovf_flag <= (64'(bus.bin) >= OVF_LIMIT);
          end
        end
        SHIFT: begin
          // The top bit of the corrected scratch falls off; overflow saturates instead.
          {scratch, shreg} <= {scratch_adj[BCD_W-2:0], shreg, 1'b0};
          cnt              <= cnt - CNT_W'(1);
        end
        LOAD: begin
          bus.bcd      <= ovf_flag ? {DIGIT_COUNT{4'h9}} : scratch;
          bus.overflow <= ovf_flag;
          bus.done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
